nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder.sv | 159 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle add/subtract unit: one 4-bit carry-lookahead slice is walked
// across the operands one nibble per clock and the result is assembled in place.

module nibble_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       gp,
    output logic       pp,
    output logic       c3
);
    logic [3:0] g, p, c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        gp   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pp   = &p;
        s    = p ^ c;
        c3   = c[3];
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               c_q, c_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [3:0] nib_a, nib_b, nib_s;
    logic       nib_gp, nib_pp, nib_c3, nib_co;
    logic       last_nib;

    assign nib_a    = opa_q[{idx_q, 2'b00} +: 4];
    assign nib_b    = opb_q[{idx_q, 2'b00} +: 4];
    assign nib_co   = nib_gp | (nib_pp & c_q);
    assign last_nib = (idx_q == IDX_W'(N - 1));

    nibble_cla4 u_slice (
        .a  (nib_a),
        .b  (nib_b),
        .ci (c_q),
        .s  (nib_s),
        .gp (nib_gp),
        .pp (nib_pp),
        .c3 (nib_c3)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        c_d      = c_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B here, the +1 rides in as carry-in.
                    opa_d    = a;
                    opb_d    = sub ? ~b : b;
                    c_d      = sub;
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                result_d[{idx_q, 2'b00} +: 4] = nib_s;
                c_d   = nib_co;
                idx_d = idx_q + 1'b1;
                if (last_nib) begin
                    // nib_c3 is the carry into the MSB on the top nibble.
                    ovf_d   = nib_c3 ^ nib_co;
                    cout_d  = nib_co;
                    idx_d   = '0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            c_q      <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            c_q      <= c_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: hand-computed vectors, latency,
// busy/start interaction and asynchronous clear.

module tb_nibble_serial_adder;
    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic        sub;
    logic [31:0] a, b;
    logic        busy, done, cout, overflow;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int ndone;
    int dk;

    always #5 clock = ~clock;

    nibble_serial_adder #(.WIDTH(32)) dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                          input logic isub, input logic [31:0] er, input logic ec, input logic ev);
        int lat;
        @(negedge clock);
        start = 1'b1; a = ia; b = ib; sub = isub;
        @(posedge clock); #1;
        start = 1'b0;
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        chk({tag, "_result_cleared"}, result, 32'h0);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'd8);
        chk({tag, "_result"}, result, er);
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_overflow"}, 32'(overflow), 32'(ev));
        @(posedge clock); #1;
        chk({tag, "_done_pulse_width"}, 32'(done), 32'd0);
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
        chk({tag, "_result_held"}, result, er);
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'h0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        @(negedge clock); @(negedge clock);
        clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
        end

        run_op("add_basic", 32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0);
        run_op("add_carry", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run_op("add_ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_op("sub_neg",   32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",   32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

        // start pulses during RUN (cycle 3) and DONE (cycle 8) must be ignored
        @(negedge clock);
        start = 1'b1; a = 32'd3; b = 32'd4; sub = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        ndone = 0; dk = -1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clock); #1;
            if (done) begin
                ndone++;
                dk = k;
            end
            if (k == 2) begin start = 1'b1; a = 32'd100; b = 32'd100; end
            if (k == 3) start = 1'b0;
            if (k == 8) start = 1'b1;
            if (k == 9) begin
                start = 1'b0;
                chk("busy_ignore_busy_low", 32'(busy), 32'd0);
            end
        end
        chk("busy_ignore_done_count", 32'(ndone), 32'd1);
        chk("busy_ignore_done_cycle", 32'(dk), 32'd8);
        chk("busy_ignore_result", result, 32'h00000007);
        chk("busy_ignore_still_idle", 32'(busy), 32'd0);
        run_op("after_busy", 32'd100, 32'd100, 1'b0, 32'h000000C8, 1'b0, 1'b0);

        // asynchronous clear mid-operation
        @(negedge clock);
        start = 1'b1; a = 32'h12345678; b = 32'h11111111; sub = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1 clear = 1'b1;
        #1;
        chk("clear_busy", 32'(busy), 32'd0);
        chk("clear_done", 32'(done), 32'd0);
        chk("clear_result", result, 32'h0);
        chk("clear_cout", 32'(cout), 32'd0);
        chk("clear_overflow", 32'(overflow), 32'd0);
        @(negedge clock);
        clear = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock); #1;
            if (done) ndone++;
        end
        chk("clear_no_done", 32'(ndone), 32'd0);
        run_op("after_clear", 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
